fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_reader_skid.sv | 63 ++++++
 rtl/fifo_reader.sv | 104 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the FIFO read-side controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int DEFAULT_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_reader_skid.sv
`timescale 1ns/1ps
// Two-entry FIFO-ordered skid buffer; data_out is always the oldest entry.
// Latency: push visible on data_out/count the cycle after the push edge.
// Backpressure: pop is ignored when empty; the caller guarantees no push when full.
// Ports: r_clk/n_rst clock and async reset; push/data_in write side;
//        pop/data_out read side; count = number of stored entries (0..2).
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic            r_clk,
    input  logic            n_rst,
    input  logic            push,
    input  logic [SIZE-1:0] data_in,
    input  logic            pop,
    output logic [SIZE-1:0] data_out,
    output logic [1:0]      count
);

    logic [SIZE-1:0] head;
    logic [SIZE-1:0] tail;
    logic            do_pop;

    assign do_pop   = pop && (count != 2'd0);
    assign data_out = head;

    always_ff @(posedge r_clk or negedge n_rst) begin
        if (!n_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= data_in;
                    end else if (count == 2'd1) begin
                        tail <= data_in;
                    end
                    if (count != 2'd2) begin
                        count <= count + 2'd1;
                    end
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous capture and hand-off: occupancy unchanged.
                    if (count == 2'd1) begin
                        head <= data_in;
                    end else begin
                        head <= tail;
                        tail <= data_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
`timescale 1ns/1ps
// Pulls words from a FIFO read port into a 2-entry skid buffer and hands them downstream.
// Latency: 2 cycles from rd_en to out_valid; 1 word/cycle sustained.
// Backpressure: credit-based; rd_en stops once buffered + in-flight words would exceed 2.
// Ports: r_clk, n_rst (async active-low); enable, e_flag, fifo_data, rd_en (FIFO side);
//        out_data, out_valid, out_ready (downstream); busy (state != IDLE);
//        word_count (only when FIFO_READER_STATS_EN is defined).
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int CNT_W = 16
) (
    input  logic             r_clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic             e_flag,
    input  logic [SIZE-1:0]  fifo_data,
    output logic             rd_en,
    output logic [SIZE-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [CNT_W-1:0] word_count
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    state_t     state;
    state_t     state_nxt;
    logic       in_flight;
    logic [1:0] stored;
    logic       pop;
    logic       has_credit;

    assign out_valid = (stored != 2'd0);
    assign pop       = out_valid && out_ready;
    assign busy      = (state != IDLE);

    // A word leaving this cycle frees its slot in time for the next capture,
    // which is what allows back-to-back pops at full rate.
    assign has_credit = ({1'b0, stored} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop});

    always_ff @(posedge r_clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            in_flight <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_flight <= rd_en;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                rd_en = !e_flag && has_credit;
                if (!enable) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if ((stored == 2'd0) && !in_flight) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO read data arrives one cycle after rd_en, so in_flight is the capture strobe.
    fifo_reader_skid #(
        .SIZE(SIZE)
    ) u_skid (
        .r_clk    (r_clk),
        .n_rst    (n_rst),
        .push     (in_flight),
        .data_in  (fifo_data),
        .pop      (pop),
        .data_out (out_data),
        .count    (stored)
    );

`ifdef FIFO_READER_STATS_EN
    always_ff @(posedge r_clk or negedge n_rst) begin
        if (!n_rst) begin
            word_count <= '0;
        end else if (pop) begin
            word_count <= word_count + CNT_W'(1);
        end
    end
`endif

endmodule
